board_io_frontend: RTL



---
 rtl/board_io_pkg.sv | 25 ++
 rtl/board_io_frontend_key_conditioner.sv | 133 +++++++++++++
 rtl/board_io_frontend.sv | 79 +++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared constants, types and helpers for the board I/O front end.
package board_io_pkg;

    localparam int MAX_KEYS           = 16;
    localparam int DEF_NUM_KEYS       = 4;
    localparam int DEF_CLK_DIV        = 2;
    localparam int DEF_KEY_ACTIVE_LOW = 0;
    localparam int DEF_DEB_TICKS      = 1000;
    localparam int DEF_DEB_SAMPLES    = 4;
    localparam int DEF_REPEAT_DELAY   = 30;
    localparam int DEF_REPEAT_RATE    = 8;

    typedef logic [MAX_KEYS-1:0] key_vec_t;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_t;

    // Bits needed to count 0..range-1; a one-value range still gets one bit.
    function automatic int cntWidth(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/board_io_frontend_key_conditioner.sv
// One key: 2-flop synchroniser, polarity normalise, debounce FSM and pulses.
// Auto-repeat of the press pulse is built only when BOARD_IO_AUTOREPEAT_EN is defined.
module key_conditioner
    import board_io_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int DEB_SAMPLES    = DEF_DEB_SAMPLES
`ifdef BOARD_IO_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic keyRaw_i,
    input  logic debTick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic IDLE_RAW = (KEY_ACTIVE_LOW != 0);
    localparam int DEB_W = cntWidth(DEB_SAMPLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SAMPLES - 1);

    logic             sync1_q, sync2_q;
    logic             keyNow;
    key_state_t       state_q, state_d;
    logic [DEB_W-1:0] debCnt_q, debCnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             flip;

`ifdef BOARD_IO_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W = cntWidth(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_V = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_V  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic [REP_W-1:0] repNext, repTarget;
    logic             repRate_q, repRate_d;
`endif

    // Sync flops idle at the unpressed pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= keyRaw_i;
            sync2_q <= sync1_q;
        end
    end

    assign keyNow = sync2_q ^ IDLE_RAW;

    always_comb begin
        state_d   = state_q;
        debCnt_d  = debCnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        flip      = 1'b0;
        if (debTick_i) begin
            if (keyNow == (state_q == KEY_PRESSED)) begin
                debCnt_d = '0;
            end else if (debCnt_q == DEB_LAST) begin
                flip     = 1'b1;
                debCnt_d = '0;
                if (keyNow) begin
                    state_d = KEY_PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d   = KEY_RELEASED;
                    release_d = 1'b1;
                end
            end else begin
                debCnt_d = debCnt_q + 1'b1;
            end
        end
`ifdef BOARD_IO_AUTOREPEAT_EN
        // Repeat timer first waits REPEAT_DELAY ticks, then REPEAT_RATE ticks per pulse.
        repCnt_d  = repCnt_q;
        repRate_d = repRate_q;
        repNext   = repCnt_q + 1'b1;
        repTarget = repRate_q ? REP_RATE_V : REP_DELAY_V;
        if (state_d == KEY_RELEASED) begin
            repCnt_d  = '0;
            repRate_d = 1'b0;
        end else if (debTick_i && !flip) begin
            if (repNext == repTarget) begin
                press_d   = 1'b1;
                repCnt_d  = '0;
                repRate_d = 1'b1;
            end else begin
                repCnt_d = repNext;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= KEY_RELEASED;
            debCnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            debCnt_q  <= debCnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BOARD_IO_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repCnt_q  <= '0;
            repRate_q <= 1'b0;
        end else begin
            repCnt_q  <= repCnt_d;
            repRate_q <= repRate_d;
        end
    end
`endif

    assign level_o   = (state_q == KEY_PRESSED);
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/board_io_frontend.sv
// Board front end: pixel clock-enable, shared debounce strobe and NUM_KEYS conditioned keys.
// Define BOARD_IO_AUTOREPEAT_EN to add auto-repeat press pulses on held keys.
module board_io_frontend
    import board_io_pkg::*;
#(
    parameter int NUM_KEYS       = DEF_NUM_KEYS,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int DEB_TICKS      = DEF_DEB_TICKS,
    parameter int DEB_SAMPLES    = DEF_DEB_SAMPLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic                pix_ce,
    output logic                deb_tick,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic [NUM_KEYS-1:0] keys_press,
    output logic [NUM_KEYS-1:0] keys_release
);

    localparam int PIX_W = cntWidth(CLK_DIV);
    localparam int TCK_W = cntWidth(DEB_TICKS);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CLK_DIV - 1);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(DEB_TICKS - 1);

    logic [PIX_W-1:0] pixCnt_q, pixCnt_d;
    logic [TCK_W-1:0] tckCnt_q, tckCnt_d;
    logic             pixCe_q, pixCe_d;
    logic             debTick_q, debTick_d;

    // Strobes are registered one clk after their counter hits its terminal value.
    always_comb begin
        pixCnt_d  = (pixCnt_q == PIX_LAST) ? '0 : pixCnt_q + 1'b1;
        pixCe_d   = (pixCnt_q == PIX_LAST);
        tckCnt_d  = (tckCnt_q == TCK_LAST) ? '0 : tckCnt_q + 1'b1;
        debTick_d = (tckCnt_q == TCK_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixCnt_q  <= '0;
            pixCe_q   <= 1'b0;
            tckCnt_q  <= '0;
            debTick_q <= 1'b0;
        end else begin
            pixCnt_q  <= pixCnt_d;
            pixCe_q   <= pixCe_d;
            tckCnt_q  <= tckCnt_d;
            debTick_q <= debTick_d;
        end
    end

    assign pix_ce   = pixCe_q;
    assign deb_tick = debTick_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_conditioner #(
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .DEB_SAMPLES   (DEB_SAMPLES)
`ifdef BOARD_IO_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
`endif
        ) u_key (
            .clk       (clk),
            .reset     (reset),
            .keyRaw_i  (keys_raw[k]),
            .debTick_i (debTick_q),
            .level_o   (keys_level[k]),
            .press_o   (keys_press[k]),
            .release_o (keys_release[k])
        );
    end

endmodule
